// File: rtl/seq_comparator.sv
// Multi-cycle magnitude comparator: walks two operands MSB-first one chunk per clock,
// stopping at the first differing chunk, and reports a selectable compare result plus gt/eq/lt.
module seq_comparator #(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8,
    parameter int RES_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             sgn,
    input  logic [1:0]       op,
    output logic             busy,
    output logic             done,
    output logic [RES_W-1:0] G,
    output logic             gt,
    output logic             eq,
    output logic             lt
);

    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int IDX_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NCHUNK - 1);

    localparam logic [1:0] OP_GT = 2'b00;
    localparam logic [1:0] OP_LT = 2'b01;
    localparam logic [1:0] OP_EQ = 2'b10;
    localparam logic [1:0] OP_GE = 2'b11;

    generate
        if (CHUNK < 1 || CHUNK > WIDTH || (WIDTH % CHUNK) != 0) begin : g_bad_chunk
            $error("seq_comparator: CHUNK must divide WIDTH and lie in 1..WIDTH");
        end
        if (RES_W < 1) begin : g_bad_res
            $error("seq_comparator: RES_W must be at least 1");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FIN
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [IDX_W-1:0] idx;
    logic [IDX_W-1:0] idx_nxt;
    logic             accept;

    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic             sgn_q;
    logic [1:0]       op_q;

    logic [CHUNK-1:0] a_chunk;
    logic [CHUNK-1:0] b_chunk;
    logic             decide;
    logic             dec_gt;
    logic             dec_eq;
    logic             dec_lt;
    logic             res;

    // Select the chunk currently under examination from the latched operands.
    always_comb begin
        a_chunk = '0;
        b_chunk = '0;
        for (int i = 0; i < NCHUNK; i++) begin
            if (idx == IDX_W'(i)) begin
                a_chunk = a_q[i*CHUNK +: CHUNK];
                b_chunk = b_q[i*CHUNK +: CHUNK];
            end
        end
    end

    // Differing sign bits settle a signed compare at once; with equal signs,
    // two's-complement ordering matches the plain unsigned ordering of the bits.
    always_comb begin
        decide = 1'b0;
        dec_gt = 1'b0;
        dec_eq = 1'b0;
        dec_lt = 1'b0;
        if (sgn_q && (idx == LAST_IDX) && (a_chunk[CHUNK-1] != b_chunk[CHUNK-1])) begin
            decide = 1'b1;
            dec_lt = a_chunk[CHUNK-1];
            dec_gt = ~a_chunk[CHUNK-1];
        end else if (a_chunk != b_chunk) begin
            decide = 1'b1;
            dec_gt = (a_chunk > b_chunk);
            dec_lt = (a_chunk < b_chunk);
        end else if (idx == '0) begin
            decide = 1'b1;
            dec_eq = 1'b1;
        end
    end

    always_comb begin
        res = 1'b0;
        case (op_q)
            OP_GT:   res = dec_gt;
            OP_LT:   res = dec_lt;
            OP_EQ:   res = dec_eq;
            OP_GE:   res = dec_gt | dec_eq;
            default: res = 1'b0;
        endcase
    end

    // A new request is taken in IDLE and also in FIN so results can stream back-to-back.
    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        accept    = 1'b0;
        case (state)
            IDLE: begin
                if (start) accept = 1'b1;
            end
            RUN: begin
                if (decide) state_nxt = FIN;
                else        idx_nxt   = idx - 1'b1;
            end
            FIN: begin
                if (start) accept    = 1'b1;
                else       state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
        if (accept) begin
            state_nxt = RUN;
            idx_nxt   = LAST_IDX;
        end
    end

    assign busy = (state == RUN);
    assign done = (state == FIN);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            idx   <= '0;
        end else begin
            state <= state_nxt;
            idx   <= idx_nxt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q   <= '0;
            b_q   <= '0;
            sgn_q <= 1'b0;
            op_q  <= 2'b00;
        end else if (accept) begin
            a_q   <= A;
            b_q   <= B;
            sgn_q <= sgn;
            op_q  <= op;
        end
    end

    // Results only move on the edge into FIN and are held through any later RUN phase.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            G  <= '0;
            gt <= 1'b0;
            eq <= 1'b0;
            lt <= 1'b0;
        end else if ((state == RUN) && decide) begin
            G  <= RES_W'(res);
            gt <= dec_gt;
            eq <= dec_eq;
            lt <= dec_lt;
        end
    end

endmodule

// File: tb/tb_seq_comparator.sv
// Scoreboard bench for seq_comparator: a default 32/8 instance plus a 16/16 instance,
// with expected results produced by a whole-number reference model.
module tb_seq_comparator;

    typedef struct {
        logic [31:0] g;
        logic        gt;
        logic        eq;
        logic        lt;
        int          lat;
        int          acc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;

    logic        start = 1'b0;
    logic [31:0] A = '0;
    logic [31:0] B = '0;
    logic        sgn = 1'b0;
    logic [1:0]  op = 2'b00;
    logic        busy, done, gt, eq, lt;
    logic [31:0] G;

    logic        start16 = 1'b0;
    logic [15:0] A16 = '0;
    logic [15:0] B16 = '0;
    logic        sgn16 = 1'b0;
    logic [1:0]  op16 = 2'b00;
    logic        busy16, done16, gt16, eq16, lt16;
    logic [15:0] G16;

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    exp_t exp_q[$];
    exp_t exp16_q[$];

    seq_comparator #(.WIDTH(32), .CHUNK(8), .RES_W(32)) dut (
        .clk(clk), .rst(rst), .start(start), .A(A), .B(B), .sgn(sgn), .op(op),
        .busy(busy), .done(done), .G(G), .gt(gt), .eq(eq), .lt(lt)
    );

    seq_comparator #(.WIDTH(16), .CHUNK(16), .RES_W(16)) dut16 (
        .clk(clk), .rst(rst), .start(start16), .A(A16), .B(B16), .sgn(sgn16), .op(op16),
        .busy(busy16), .done(done16), .G(G16), .gt(gt16), .eq(eq16), .lt(lt16)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    // Relation from signed/unsigned integer values; latency from the highest differing bit.
    function automatic exp_t refModel(input logic [31:0] a, input logic [31:0] b, input int w,
                                      input int chunk, input bit s, input logic [1:0] o);
        exp_t        e;
        longint      va, vb;
        logic [31:0] x;
        int          n, k, p;
        bit          r;
        n  = w / chunk;
        va = longint'(a);
        vb = longint'(b);
        if (s && a[w-1]) va = va - (longint'(1) << w);
        if (s && b[w-1]) vb = vb - (longint'(1) << w);
        e.gt = (va > vb);
        e.eq = (va == vb);
        e.lt = (va < vb);
        case (o)
            2'b00:   r = e.gt;
            2'b01:   r = e.lt;
            2'b10:   r = e.eq;
            default: r = e.gt | e.eq;
        endcase
        e.g = 32'(r);
        x = a ^ b;
        p = -1;
        for (int j = 0; j < w; j++) if (x[j]) p = j;
        if (s && (a[w-1] != b[w-1])) k = 1;
        else if (p < 0)              k = n;
        else                         k = n - p / chunk;
        e.lat = k + 1;
        e.acc = 0;
        return e;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] expv);
        checks++;
        if (got !== expv) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h (t=%0t)", name, got, expv, $time);
        end
    endtask

    // Drives one request at posedge+2; it is expected to be taken only if the DUT is not busy.
    task automatic applyStimulus(input int sel, input logic [31:0] a, input logic [31:0] b,
                                 input bit s, input logic [1:0] o);
        exp_t e;
        bit   acc;
        if (sel == 0) begin
            A = a; B = b; sgn = s; op = o; start = 1'b1;
            acc = !busy && !rst;
            e = refModel(a, b, 32, 8, s, o);
            e.acc = cyc;
            if (acc) exp_q.push_back(e);
        end else begin
            A16 = a[15:0]; B16 = b[15:0]; sgn16 = s; op16 = o; start16 = 1'b1;
            acc = !busy16 && !rst;
            e = refModel({16'h0, a[15:0]}, {16'h0, b[15:0]}, 16, 16, s, o);
            e.acc = cyc;
            if (acc) exp16_q.push_back(e);
        end
        @(posedge clk);
        #2;
        start = 1'b0;
        start16 = 1'b0;
        if (acc && sel == 0) checkOutput("busy_after_accept", 32'(busy), 32'd1);
        if (acc && sel != 0) checkOutput("busy16_after_accept", 32'(busy16), 32'd1);
    endtask

    task automatic waitDone(input int sel, input int budget);
        int n = 0;
        while (((sel == 0) ? !done : !done16) && n < budget) begin
            @(posedge clk);
            #2;
            n++;
        end
        if ((sel == 0) ? !done : !done16) begin
            checks++;
            errors++;
            $display("[TB] FAIL wait_done: got no done after %0d cycles expected done", budget);
        end
    endtask

    task automatic waitEmpty(input int budget);
        int n = 0;
        while ((exp_q.size() != 0 || exp16_q.size() != 0) && n < budget) begin
            @(posedge clk);
            #2;
            n++;
        end
        checks++;
        if (exp_q.size() != 0 || exp16_q.size() != 0) begin
            errors++;
            $display("[TB] FAIL pending_results: got %0d outstanding expected 0",
                     exp_q.size() + exp16_q.size());
            exp_q.delete();
            exp16_q.delete();
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (!rst && done) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpected_done: got done=1 expected no pending request");
            end else begin
                e = exp_q.pop_front();
                checkOutput("G", G, e.g);
                checkOutput("gt", 32'(gt), 32'(e.gt));
                checkOutput("eq", 32'(eq), 32'(e.eq));
                checkOutput("lt", 32'(lt), 32'(e.lt));
                checkOutput("latency", 32'(cyc - e.acc), 32'(e.lat));
                checkOutput("busy_at_done", 32'(busy), 32'd0);
            end
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (!rst && done16) begin
            if (exp16_q.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpected_done16: got done=1 expected no pending request");
            end else begin
                e = exp16_q.pop_front();
                checkOutput("G16", {16'h0, G16}, e.g);
                checkOutput("gt16", 32'(gt16), 32'(e.gt));
                checkOutput("eq16", 32'(eq16), 32'(e.eq));
                checkOutput("lt16", 32'(lt16), 32'(e.lt));
                checkOutput("latency16", 32'(cyc - e.acc), 32'(e.lat));
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got no completion expected finish before timeout");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [31:0] a, b;
        bit          s;
        logic [1:0]  o;
        int          mode;

        #1 rst = 1'b1;
        #1;
        checkOutput("reset_busy", 32'(busy), 32'd0);
        checkOutput("reset_done", 32'(done), 32'd0);
        checkOutput("reset_G", G, 32'd0);
        checkOutput("reset_flags", {29'd0, gt, eq, lt}, 32'd0);
        @(posedge clk);
        @(posedge clk);
        #2 rst = 1'b0;

        applyStimulus(0, 32'd5, 32'd3, 1'b0, 2'b00);
        waitEmpty(10);
        applyStimulus(0, 32'hFFFF_FFFF, 32'd1, 1'b1, 2'b00);
        waitEmpty(10);
        applyStimulus(0, 32'hFFFF_FFFF, 32'd1, 1'b0, 2'b00);
        waitEmpty(10);
        applyStimulus(0, 32'h1234_5678, 32'h1234_5678, 1'b0, 2'b10);
        waitEmpty(10);
        applyStimulus(0, 32'h1234_5678, 32'h1234_5678, 1'b1, 2'b11);
        waitEmpty(10);
        applyStimulus(0, 32'h1234_5678, 32'h1234_5678, 1'b0, 2'b01);
        waitEmpty(10);

        // Start during RUN must be ignored; start in FIN must be taken.
        applyStimulus(0, 32'h4000_0000, 32'h4000_0001, 1'b0, 2'b00);
        applyStimulus(0, 32'd7, 32'd1, 1'b0, 2'b00);
        waitDone(0, 10);
        applyStimulus(0, 32'd2, 32'd9, 1'b0, 2'b01);
        waitEmpty(10);

        // Abort a 4-chunk compare in its second RUN cycle.
        applyStimulus(0, 32'h1122_3344, 32'h1122_3345, 1'b0, 2'b00);
        @(posedge clk);
        #2 rst = 1'b1;
        exp_q.delete();
        #1;
        checkOutput("abort_busy", 32'(busy), 32'd0);
        checkOutput("abort_done", 32'(done), 32'd0);
        checkOutput("abort_G", G, 32'd0);
        @(posedge clk);
        #2 rst = 1'b0;
        repeat (8) @(posedge clk);
        #2;
        applyStimulus(0, 32'd5, 32'd3, 1'b0, 2'b00);
        waitEmpty(10);

        applyStimulus(1, 32'h0000_8000, 32'h0000_7FFF, 1'b1, 2'b01);
        waitEmpty(10);
        applyStimulus(1, 32'h0000_8000, 32'h0000_7FFF, 1'b0, 2'b01);
        waitEmpty(10);

        for (int i = 0; i < 60; i++) begin
            a = $urandom;
            mode = $urandom_range(0, 3);
            case (mode)
                0:       b = $urandom;
                1:       b = a;
                2:       b = a ^ (32'h1 << $urandom_range(0, 31));
                default: b = {a[31:16], 16'($urandom)};
            endcase
            s = 1'($urandom_range(0, 1));
            o = 2'($urandom_range(0, 3));
            applyStimulus(0, a, b, s, o);
            waitDone(0, 10);
            if ($urandom_range(0, 1) == 0) waitEmpty(10);
        end
        waitEmpty(10);

        for (int i = 0; i < 10; i++) begin
            a = $urandom;
            b = (i % 3 == 0) ? a : $urandom;
            applyStimulus(1, a, b, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)));
            waitEmpty(10);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/seq_comparator.md
# seq_comparator

Parametrised multi-cycle magnitude comparator for the ALU. It compares two WIDTH-bit operands MSB-first, CHUNK bits per clock, stopping early at the first differing chunk. It supports signed and unsigned modes and four compare ops, and returns a RES_W-bit flag word (result in bit 0) plus gt/eq/lt flags. It replaces the single-function combinational signed-greater-than comparator in the ALU compare path where timing closure matters more than latency.

## Interface
- WIDTH, 32, operand width; must be a multiple of CHUNK.
- CHUNK, 8, bits compared per cycle; 1..WIDTH.
- RES_W, 32, width of result word G.
- clk  in  1  clock, all state on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- start  in  1  request; accepted only when busy=0.
- A  in  WIDTH  operand A, sampled on accepted start.
- B  in  WIDTH  operand B, sampled on accepted start.
- sgn  in  1  1 = two's-complement signed, 0 = unsigned; sampled with start.
- op  in  2  00 GT (A>B), 01 LT (A<B), 10 EQ, 11 GE (A>=B); sampled with start.
- busy  out  1  high while comparing.
- done  out  1  one-cycle pulse, result valid.
- G  out  RES_W  G[0] = selected op result, G[RES_W-1:1] = 0; held until next accepted start.
- gt, eq, lt  out  1  raw relation flags, one-hot when valid; held with G.

## Operation
- States: IDLE, RUN, FIN.
- IDLE: busy=0. start=1 → latch A, B, sgn, op; idx = WIDTH/CHUNK-1; go to RUN.
- RUN: busy=1. Compare chunk idx of latched A vs B.
  - Chunks differ → decide gt/lt from the chunk and go to FIN.
  - Chunks equal and idx=0 → eq=1, go to FIN.
  - Otherwise idx decrements; stay in RUN.
- Signed rule, top chunk only: if the sign bits differ, the operand with sign bit 1 is smaller, decided in that cycle. Otherwise the top and all lower chunks use plain unsigned compare.
- FIN: done=1, busy=0. G, gt, eq, lt were registered on entry to FIN.
  - start=1 in FIN is accepted and goes to RUN, giving back-to-back operation.
  - Otherwise go to IDLE.
- G[0] by op: GT=gt, LT=lt, EQ=eq, GE=gt|eq.
- start while in RUN is ignored; latched operands are not disturbed.
- A, B, sgn and op changing after acceptance have no effect.

## Timing
- Reset values: state IDLE, busy 0, done 0, G 0, gt 0, eq 0, lt 0, idx 0.
- start accepted on edge 0. RUN occupies cycles 1..k, where k = number of chunks examined (1..WIDTH/CHUNK). done=1 in cycle k+1.
- Latency: minimum 2 cycles, maximum WIDTH/CHUNK+1 cycles. WIDTH=32, CHUNK=8 gives a maximum of 5.
- busy rises the cycle after acceptance and falls in the FIN cycle.
- G and flags update only on the edge entering FIN.
- rst mid-operation aborts immediately: all outputs return to reset values and no done pulse is produced.
- CHUNK=WIDTH degenerates to a fixed 2-cycle latency.

## Test plan
- Unsigned equal-prefix case. A=5, B=3, sgn=0, op=GT: 4 RUN cycles, done in cycle 5, G=1, gt=1, eq=0, lt=0.
- Early exit on sign bits.
  - A=0xFFFFFFFF, B=1, sgn=1, op=GT: done in cycle 2, G=0, lt=1.
  - Same operands with sgn=0: done in cycle 2, G=1, gt=1.
- Equality. A=B=0x12345678:
  - op=EQ: done in cycle 5, G=1, eq=1.
  - op=GE: G=1.
  - op=LT: G=0.
- Handshake.
  - start pulsed during RUN with new operands: ignored, first result unaffected.
  - start asserted in the FIN cycle with A=2, B=9, op=LT: accepted; next done gives G=1.
- Reset mid-operation. rst asserted in cycle 2 of a 4-chunk compare: busy, done and G go to 0 asynchronously, no done pulse follows; a subsequent start completes normally.
- Parameter sweep WIDTH=16, CHUNK=16, RES_W=16. A=0x8000, B=0x7FFF:
  - sgn=1, op=LT: done in cycle 2, G=0x0001.
  - sgn=0: G=0x0000.
